// File: rtl/cracker_host.sv
// cracker_host: host end of the hash-cracker UART byte protocol.
// Streams a job (8 alphabet lines, seed, goal) out and parses 10-byte reply lines.
module cracker_host (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic [31:0] goal,
    input  logic        alpha_valid,
    input  logic [7:0]  alpha_data,
    output logic        alpha_ready,
    input  logic        tx_ready,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        evt_reset,
    output logic        evt_start,
    output logic        result_valid,
    output logic [55:0] result_str,
    output logic [15:0] result_count,
    output logic        job_done,
    output logic        job_err,
    output logic        frame_err
);
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_SEND_ALPHA = 3'd1;
    localparam logic [2:0] S_SEND_SEED  = 3'd2;
    localparam logic [2:0] S_SEND_GOAL  = 3'd3;
    localparam logic [2:0] S_WAIT_START = 3'd4;
    localparam logic [2:0] S_RUNNING    = 3'd5;

    localparam logic [7:0]  LF = 8'h0A;
    localparam logic [7:0]  CR = 8'h0D;
    localparam logic [55:0] LINE_RESET = {7'd32, 7'd32, 7'd32, 7'd84, 7'd69, 7'd83, 7'd69, 7'd82};
    localparam logic [55:0] LINE_START = {7'd32, 7'd32, 7'd32, 7'd84, 7'd82, 7'd65, 7'd84, 7'd83};

    logic [2:0]  r_state;
    logic [31:0] r_seed;
    logic [31:0] r_goal;
    logic        r_guard;
    logic [2:0]  r_lf_cnt;
    logic [1:0]  r_byte_cnt;
    logic        r_tx_send;
    logic [7:0]  r_tx_data;
    logic [3:0]  r_rx_pos;
    logic        r_discard;
    logic [55:0] r_line;
    logic        r_evt_reset;
    logic        r_evt_start;
    logic        r_result_valid;
    logic        r_frame_err;
    logic [55:0] r_result_str;
    logic [15:0] r_result_count;

    logic       w_busy;
    logic       w_abort;
    logic       w_can_send;
    logic       w_alpha_take;
    logic       w_accept;
    logic [7:0] w_seed_byte;
    logic [7:0] w_goal_byte;

    assign w_busy       = (r_state != S_IDLE);
    assign w_abort      = r_evt_reset && w_busy;
    // guard covers the cycle tx_send is high, before the UART can drop tx_ready
    assign w_can_send   = tx_ready && !r_guard && !w_abort;
    assign w_alpha_take = (r_state == S_SEND_ALPHA) && alpha_valid && w_can_send;
    assign w_accept     = start && (r_state == S_IDLE);
    assign w_seed_byte  = r_seed[{r_byte_cnt, 3'b000} +: 8];
    assign w_goal_byte  = r_goal[{r_byte_cnt, 3'b000} +: 8];

    assign alpha_ready  = (r_state == S_SEND_ALPHA) && w_can_send;
    assign busy         = w_busy;
    assign tx_send      = r_tx_send;
    assign tx_data      = r_tx_data;
    assign job_done     = r_evt_reset && (r_state == S_RUNNING);
    assign job_err      = w_abort && (r_state != S_RUNNING);
    assign evt_reset    = r_evt_reset;
    assign evt_start    = r_evt_start;
    assign result_valid = r_result_valid;
    assign result_str   = r_result_str;
    assign result_count = r_result_count;
    assign frame_err    = r_frame_err;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_seed <= seed;
            r_goal <= goal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_guard    <= 1'b0;
            r_lf_cnt   <= 3'd0;
            r_byte_cnt <= 2'd0;
            r_tx_send  <= 1'b0;
            r_tx_data  <= 8'd0;
        end else begin
            r_tx_send <= 1'b0;
            r_guard   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_SEND_ALPHA;
                        r_lf_cnt   <= 3'd0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                S_SEND_ALPHA: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_alpha_take) begin
                        r_tx_send <= 1'b1;
                        r_guard   <= 1'b1;
                        r_tx_data <= alpha_data;
                        if (alpha_data == LF) begin
                            r_lf_cnt <= r_lf_cnt + 3'd1;
                            if (r_lf_cnt == 3'd7) r_state <= S_SEND_SEED;
                        end
                    end
                end
                S_SEND_SEED: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_can_send) begin
                        r_tx_send  <= 1'b1;
                        r_guard    <= 1'b1;
                        r_tx_data  <= w_seed_byte;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) r_state <= S_SEND_GOAL;
                    end
                end
                S_SEND_GOAL: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_can_send) begin
                        r_tx_send  <= 1'b1;
                        r_guard    <= 1'b1;
                        r_tx_data  <= w_goal_byte;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) r_state <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (w_abort)          r_state <= S_IDLE;
                    else if (r_evt_start) r_state <= S_RUNNING;
                end
                S_RUNNING: begin
                    if (r_evt_reset) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // line buffer: first character received ends up in char 0
    always_ff @(posedge clk) begin
        if (rx_valid && !r_discard && (r_rx_pos < 4'd8) && (rx_data != LF) && !rx_data[7])
            r_line <= {rx_data[6:0], r_line[55:7]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_pos       <= 4'd0;
            r_discard      <= 1'b0;
            r_evt_reset    <= 1'b0;
            r_evt_start    <= 1'b0;
            r_result_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            r_result_str   <= 56'd0;
            r_result_count <= 16'd0;
        end else begin
            r_evt_reset    <= 1'b0;
            r_evt_start    <= 1'b0;
            r_result_valid <= 1'b0;
            r_frame_err    <= 1'b0;
            if (w_accept) r_result_count <= 16'd0;
            if (rx_valid) begin
                if (r_discard) begin
                    if (rx_data == LF) r_discard <= 1'b0;
                end else if (r_rx_pos < 4'd8) begin
                    if (rx_data == LF) begin
                        r_frame_err <= 1'b1;
                        r_rx_pos    <= 4'd0;
                    end else if (rx_data[7]) begin
                        r_frame_err <= 1'b1;
                        r_discard   <= 1'b1;
                        r_rx_pos    <= 4'd0;
                    end else begin
                        r_rx_pos <= r_rx_pos + 4'd1;
                    end
                end else if (r_rx_pos == 4'd8) begin
                    if (rx_data == CR) begin
                        r_rx_pos <= 4'd9;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_rx_pos    <= 4'd0;
                        r_discard   <= (rx_data != LF);
                    end
                end else begin
                    r_rx_pos <= 4'd0;
                    if (rx_data == LF) begin
                        if (r_line == LINE_RESET) begin
                            r_evt_reset <= 1'b1;
                        end else if (r_line == LINE_START) begin
                            r_evt_start <= 1'b1;
                        end else begin
                            r_result_valid <= 1'b1;
                            r_result_str   <= r_line;
                            if (!w_accept && (r_result_count != 16'hFFFF))
                                r_result_count <= r_result_count + 16'd1;
                        end
                    end else begin
                        r_frame_err <= 1'b1;
                        r_discard   <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
